d8m_sensor_init_sequencer: RTL and testbench
============================================

// Module: d8m_sensor_init_sequencer
// PURPOSE
//  Brings up the D8M camera after configuration: waits for PLL lock, sequences MIPI
//  PWDN_N/RESET_N with timed holds, then streams a register table to the I2C master
//  one entry at a time over a valid/ready + done handshake. Retries NACKed writes.
//  Sits between the PLL locked conduit, the mipi_pwdn_n/mipi_reset_n pins and the
//  camera/MIPI-bridge I2C command port; asserts done before the pixel path is enabled.
// PARAMETERS
//  PWDN_DLY   1000   cycles PWDN_N stays low after lock
//  RST_DLY    2000   cycles RESET_N stays low after PWDN_N rises
//  BOOT_DLY   50000  cycles after RESET_N rises before first I2C write
//  NUM_REGS   64     table entries, indices 0..NUM_REGS-1
//  MAX_RETRY  3      extra attempts per entry after a NACK
//  DLY_UNIT   1000   cycles per count of a delay entry
//  DEV_ADDR   7'h36  7-bit I2C device address driven on cmd_dev
// PORTS
//  clk_clk        in   1   system clock
//  reset_reset_n  in   1   asynchronous active-low reset
//  start          in   1   one-cycle pulse: begin sequence; ignored while busy
//  pll_locked     in   1   PLL locked status
//  mipi_pwdn_n    out  1   sensor power-down, active low
//  mipi_reset_n   out  1   sensor reset, active low
//  rom_addr       out  clog2(NUM_REGS)  table index
//  rom_data       in   24  {reg_addr[23:8], value[7:0]}, valid 1 cycle after rom_addr
//  cmd_valid      out  1   I2C write request
//  cmd_ready      in   1   I2C master accepts request
//  cmd_dev        out  7   device address (DEV_ADDR)
//  cmd_reg        out  16  register address
//  cmd_data       out  8   write value
//  cmd_done       in   1   one-cycle pulse: transfer finished
//  cmd_nack       in   1   qualified by cmd_done: transfer NACKed
//  busy           out  1   high from start until DONE/FAIL
//  done           out  1   sticky: table fully written
//  error          out  1   sticky: retries exhausted or lock lost
//  err_index      out  clog2(NUM_REGS)  index of failing entry
// BEHAVIOUR
//  Reset: pwdn_n=0, reset_n=0, cmd_valid=0, rom_addr=0, busy=done=error=0, err_index=0, state IDLE.
//  IDLE: start -> WAIT_LOCK; clears done, error, err_index; busy=1 from next cycle.
//  WAIT_LOCK: pwdn_n=0, reset_n=0; pll_locked=1 -> PWDN_HOLD, counter cleared.
//  PWDN_HOLD: count PWDN_DLY cycles, then pwdn_n=1 -> RST_HOLD.
//  RST_HOLD: count RST_DLY cycles, then reset_n=1 -> BOOT_WAIT.
//  BOOT_WAIT: count BOOT_DLY cycles -> FETCH with rom_addr=0, retry count 0.
//  FETCH: one cycle for ROM latency; register rom_data -> ISSUE.
//  Delay entry (reg_addr==16'hFFFF): no I2C; wait value*DLY_UNIT cycles (value 0 = 0 cycles) then NEXT.
//  ISSUE: cmd_valid=1 with cmd_reg/cmd_data stable until cmd_valid&cmd_ready; -> WAIT_DONE.
//  WAIT_DONE: cmd_done&!cmd_nack -> NEXT; cmd_done&cmd_nack: retry<MAX_RETRY -> retry++, ISSUE;
//   else -> FAIL with err_index=rom_addr.
//  NEXT: rom_addr==NUM_REGS-1 -> DONE, else rom_addr++, retry=0, FETCH.
//  DONE: done=1, busy=0; pins stay released; start restarts full sequence from WAIT_LOCK.
//  FAIL: error=1, busy=0, pwdn_n=0, reset_n=0; start restarts.
//  pll_locked=0 in any state after WAIT_LOCK and before DONE: pins reasserted low next cycle,
//   cmd_valid dropped only if not yet accepted, error=1, err_index=rom_addr, -> FAIL.
//  Accepted transfer in flight when lock lost: cmd_done ignored.
//  Delay counters sized for max(PWDN_DLY,RST_DLY,BOOT_DLY,255*DLY_UNIT); no wrap.
//  start coincident with reset deassertion edge is ignored; start while busy ignored.
// TESTING
//  (bench: PWDN_DLY=4, RST_DLY=8, BOOT_DLY=16, NUM_REGS=3, MAX_RETRY=1, DLY_UNIT=2)
//  Lock high, start -> pwdn_n rises 4 cycles after lock seen, reset_n 8 later, first cmd_valid >=16 later.
//  Table {0x3000_12,0xFFFF_03,0x3001_34} -> two writes in order, exactly 6-cycle gap for delay entry, done=1.
//  Entry 1 NACKed once then ACKed -> same entry reissued once, done=1, error=0.
//  Entry 2 NACKed twice -> error=1, err_index=2, pins low, busy=0, no further cmd_valid.
//  pll_locked drops during ISSUE with cmd_ready=0 -> cmd_valid falls, pins low next cycle, error=1.
//  reset_reset_n asserted mid-WAIT_DONE -> all outputs at reset values immediately (async).

Source files
------------

// File: rtl/d8m_sensor_init_sequencer_if.sv
// -----------------------------------------------------------------------------
// d8m_sensor_init_sequencer_if
// Purpose : I2C write-command channel between the D8M init sequencer and the
//           I2C master. One request is a (device, register, value) triple
//           handed over with valid/ready; completion comes back as a one-cycle
//           done pulse with nack qualifying it.
// Signals : cmd_valid  request present (sequencer -> I2C master)
//           cmd_ready  request accepted (I2C master -> sequencer)
//           cmd_dev    7-bit I2C device address
//           cmd_reg    16-bit register address
//           cmd_data   8-bit write value
//           cmd_done   transfer finished pulse
//           cmd_nack   transfer NACKed, valid only with cmd_done
// Modports: master = sequencer side, slave = I2C master side.
// -----------------------------------------------------------------------------
interface d8m_sensor_init_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [6:0]  cmd_dev;
   logic [15:0] cmd_reg;
   logic [7:0]  cmd_data;
   logic        cmd_done;
   logic        cmd_nack;

   modport master (
      output cmd_valid, cmd_dev, cmd_reg, cmd_data,
      input  cmd_ready, cmd_done, cmd_nack
   );

   modport slave (
      input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
      output cmd_ready, cmd_done, cmd_nack
   );
endinterface

// File: rtl/d8m_sensor_init_sequencer.sv
// -----------------------------------------------------------------------------
// d8m_sensor_init_sequencer
// Purpose : Brings up the D8M camera. Waits for PLL lock, releases MIPI
//           PWDN_N then RESET_N after timed holds, waits for sensor boot, then
//           walks a register table (synchronous ROM) and issues one I2C write
//           per entry, retrying NACKed writes. Entries with register address
//           16'hFFFF are pure delays of value*DLY_UNIT cycles. Loss of PLL lock
//           during bring-up aborts into FAIL with the pins re-asserted.
// Ports   : clk_clk, reset_reset_n   clock, async active-low reset
//           start                    one-cycle start pulse (ignored while busy)
//           pll_locked               PLL lock status
//           mipi_pwdn_n/reset_n      sensor control pins, active low
//           rom_addr / rom_data      table index / entry, data 1 cycle later
//           cmd                      I2C command channel (master modport)
//           busy, done, error        status; done/error sticky until start
//           err_index                table index of the failing entry
// -----------------------------------------------------------------------------
module d8m_sensor_init_sequencer #(
   parameter int         PWDN_DLY  = 1000,
   parameter int         RST_DLY   = 2000,
   parameter int         BOOT_DLY  = 50000,
   parameter int         NUM_REGS  = 64,
   parameter int         MAX_RETRY = 3,
   parameter int         DLY_UNIT  = 1000,
   parameter logic [6:0] DEV_ADDR  = 7'h36,
   localparam int        AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic          clk_clk,
   input  logic          reset_reset_n,
   input  logic          start,
   input  logic          pll_locked,
   output logic          mipi_pwdn_n,
   output logic          mipi_reset_n,
   output logic [AW-1:0] rom_addr,
   input  logic [23:0]   rom_data,
   d8m_sensor_init_sequencer_if.master cmd,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] err_index
);

   // One counter serves every hold and delay entry, so it must cover the longest.
   localparam int DLY_A   = (PWDN_DLY > RST_DLY) ? PWDN_DLY : RST_DLY;
   localparam int DLY_B   = (BOOT_DLY > 255 * DLY_UNIT) ? BOOT_DLY : 255 * DLY_UNIT;
   localparam int DLY_MAX = (DLY_A > DLY_B) ? DLY_A : DLY_B;
   localparam int CW      = $clog2(DLY_MAX + 1);
   localparam int RW      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CW:0]   PWDN_T  = (CW+1)'(PWDN_DLY);
   localparam logic [CW:0]   RST_T   = (CW+1)'(RST_DLY);
   localparam logic [CW:0]   BOOT_T  = (CW+1)'(BOOT_DLY);
   localparam logic [CW-1:0] UNIT_T  = CW'(DLY_UNIT);
   localparam logic [RW-1:0] RETRY_T = RW'(MAX_RETRY);
   localparam logic [AW-1:0] LAST_T  = AW'(NUM_REGS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_WAIT_LOCK, S_PWDN_HOLD, S_RST_HOLD, S_BOOT_WAIT, S_FETCH,
      S_LATCH, S_DELAY, S_ISSUE, S_WAIT_DONE, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] dly_q, dly_d;
   logic [RW-1:0] retry_q, retry_d;
   logic [AW-1:0] rom_addr_q, rom_addr_d;
   logic [AW-1:0] err_index_q, err_index_d;
   logic [15:0]   cmd_reg_q, cmd_reg_d;
   logic [7:0]    cmd_data_q, cmd_data_d;
   logic          cmd_valid_q, cmd_valid_d;
   logic          pwdn_n_q, pwdn_n_d;
   logic          reset_n_q, reset_n_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          armed_q;
   logic [CW:0]   cnt_inc;
   logic          lock_watch;

   // Count of cycles spent in the current hold including this one.
   assign cnt_inc = {1'b0, cnt_q} + 1'b1;

   // Lock is supervised from the first hold until the table is complete.
   assign lock_watch = state_q inside {S_PWDN_HOLD, S_RST_HOLD, S_BOOT_WAIT, S_FETCH,
                                       S_LATCH, S_DELAY, S_ISSUE, S_WAIT_DONE, S_NEXT};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dly_d       = dly_q;
      retry_d     = retry_q;
      rom_addr_d  = rom_addr_q;
      err_index_d = err_index_q;
      cmd_reg_d   = cmd_reg_q;
      cmd_data_d  = cmd_data_q;
      cmd_valid_d = cmd_valid_q;
      pwdn_n_d    = pwdn_n_q;
      reset_n_d   = reset_n_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;

      case (state_q)
         S_IDLE, S_DONE, S_FAIL: begin
            // armed_q masks a start that lands on the first edge after reset.
            if (start && armed_q) begin
               state_d     = S_WAIT_LOCK;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_index_d = '0;
               pwdn_n_d    = 1'b0;
               reset_n_d   = 1'b0;
            end
         end
         S_WAIT_LOCK: begin
            if (pll_locked) begin
               state_d = S_PWDN_HOLD;
               cnt_d   = '0;
            end
         end
         S_PWDN_HOLD: begin
            if (cnt_inc >= PWDN_T) begin
               pwdn_n_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_RST_HOLD;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         S_RST_HOLD: begin
            if (cnt_inc >= RST_T) begin
               reset_n_d = 1'b1;
               cnt_d     = '0;
               state_d   = S_BOOT_WAIT;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         S_BOOT_WAIT: begin
            if (cnt_inc >= BOOT_T) begin
               rom_addr_d = '0;
               retry_d    = '0;
               state_d    = S_FETCH;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         // rom_addr_q changed on entry; the ROM presents the entry one cycle later.
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            if (rom_data[23:8] == 16'hFFFF) begin
               dly_d   = CW'(rom_data[7:0]) * UNIT_T;
               cnt_d   = '0;
               state_d = (rom_data[7:0] == 8'd0) ? S_NEXT : S_DELAY;
            end else begin
               cmd_reg_d   = rom_data[23:8];
               cmd_data_d  = rom_data[7:0];
               cmd_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_DELAY: begin
            if (cnt_inc >= {1'b0, dly_q}) begin
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_inc[CW-1:0];
            end
         end
         S_ISSUE: begin
            if (cmd.cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (cmd.cmd_done) begin
               if (!cmd.cmd_nack) begin
                  state_d = S_NEXT;
               end else if (retry_q < RETRY_T) begin
                  retry_d     = retry_q + 1'b1;
                  cmd_valid_d = 1'b1;
                  state_d     = S_ISSUE;
               end else begin
                  state_d     = S_FAIL;
                  error_d     = 1'b1;
                  busy_d      = 1'b0;
                  err_index_d = rom_addr_q;
                  pwdn_n_d    = 1'b0;
                  reset_n_d   = 1'b0;
               end
            end
         end
         S_NEXT: begin
            if (rom_addr_q == LAST_T) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               rom_addr_d = rom_addr_q + 1'b1;
               retry_d    = '0;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Lock loss overrides everything, including a done pulse in the same cycle.
      if (lock_watch && !pll_locked) begin
         state_d     = S_FAIL;
         pwdn_n_d    = 1'b0;
         reset_n_d   = 1'b0;
         cmd_valid_d = 1'b0;
         error_d     = 1'b1;
         busy_d      = 1'b0;
         err_index_d = rom_addr_q;
      end
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         dly_q       <= '0;
         retry_q     <= '0;
         rom_addr_q  <= '0;
         err_index_q <= '0;
         cmd_reg_q   <= '0;
         cmd_data_q  <= '0;
         cmd_valid_q <= 1'b0;
         pwdn_n_q    <= 1'b0;
         reset_n_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         armed_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dly_q       <= dly_d;
         retry_q     <= retry_d;
         rom_addr_q  <= rom_addr_d;
         err_index_q <= err_index_d;
         cmd_reg_q   <= cmd_reg_d;
         cmd_data_q  <= cmd_data_d;
         cmd_valid_q <= cmd_valid_d;
         pwdn_n_q    <= pwdn_n_d;
         reset_n_q   <= reset_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         armed_q     <= 1'b1;
      end
   end

   assign mipi_pwdn_n   = pwdn_n_q;
   assign mipi_reset_n  = reset_n_q;
   assign rom_addr      = rom_addr_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_index     = err_index_q;
   assign cmd.cmd_valid = cmd_valid_q;
   assign cmd.cmd_dev   = DEV_ADDR;
   assign cmd.cmd_reg   = cmd_reg_q;
   assign cmd.cmd_data  = cmd_data_q;

endmodule

// File: tb/tb_d8m_sensor_init_sequencer.sv
module tb_d8m_sensor_init_sequencer;
   localparam int P_PWDN = 4;
   localparam int P_RST  = 8;
   localparam int P_BOOT = 16;
   localparam int P_NR   = 3;
   localparam int P_MR   = 1;
   localparam int P_DU   = 2;
   localparam int AW     = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          pll_locked;
   logic          pwdn_n, reset_n;
   logic [AW-1:0] rom_addr, err_index;
   logic [23:0]   rom_data;
   logic          busy, done, error;

   d8m_sensor_init_sequencer_if bus ();

   d8m_sensor_init_sequencer #(
      .PWDN_DLY(P_PWDN), .RST_DLY(P_RST), .BOOT_DLY(P_BOOT), .NUM_REGS(P_NR),
      .MAX_RETRY(P_MR), .DLY_UNIT(P_DU), .DEV_ADDR(7'h36)
   ) dut (
      .clk_clk(clk), .reset_reset_n(rst_n), .start(start), .pll_locked(pll_locked),
      .mipi_pwdn_n(pwdn_n), .mipi_reset_n(reset_n), .rom_addr(rom_addr),
      .rom_data(rom_data), .cmd(bus.master), .busy(busy), .done(done),
      .error(error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   // Register table: synchronous ROM, entry valid one cycle after address.
   logic [23:0] tbl [P_NR];
   always @(posedge clk) rom_data <= tbl[rom_addr];

   int          tests = 0;
   int          fails = 0;
   int          cyc   = 0;
   logic [23:0] exp_q [$];
   bit          nack_q [$];
   int          acc_cyc [$];
   bit          det_mode = 1'b0;
   bit          hold_ready = 1'b0;
   int          det_done_dly = 2;
   bit          s_busy = 1'b0;
   bit          s_nack = 1'b0;
   bit          s_acc = 1'b0;
   int          s_cnt = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endfunction

   // Reference model: walk the table by the rules (delay entries produce no
   // write; each write is repeated once per NACK up to MAX_RETRY extra tries).
   task automatic plan(input int nacks [P_NR], output bit exp_done,
                       output bit exp_err, output int exp_idx);
      exp_done = 1'b1; exp_err = 1'b0; exp_idx = 0;
      exp_q.delete(); nack_q.delete();
      for (int i = 0; i < P_NR; i++) begin
         if (tbl[i][23:8] == 16'hFFFF) continue;
         for (int a = 0; a <= P_MR; a++) begin
            exp_q.push_back(tbl[i]);
            if (a < nacks[i]) begin
               nack_q.push_back(1'b1);
               if (a == P_MR) begin
                  exp_done = 1'b0; exp_err = 1'b1; exp_idx = i;
                  return;
               end
            end else begin
               nack_q.push_back(1'b0);
               break;
            end
         end
      end
   endtask

   // Monitor: every accepted command is popped against the scoreboard.
   always @(negedge clk) begin
      cyc++;
      if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
         acc_cyc.push_back(cyc);
         $display("[TB] cmd dev=%h reg=%h data=%h", bus.cmd_dev, bus.cmd_reg, bus.cmd_data);
         if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_cmd actual=%h required=none", {bus.cmd_reg, bus.cmd_data});
         end else begin
            check("cmd_entry", {8'h0, bus.cmd_reg, bus.cmd_data}, {8'h0, exp_q.pop_front()});
            check("cmd_dev", {25'h0, bus.cmd_dev}, 32'h36);
         end
      end
   end

   // I2C master model: random (or fixed) ready and completion latency.
   initial begin
      bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.cmd_nack = 1'b0;
      forever begin
         @(negedge clk);
         s_acc = bus.cmd_valid && bus.cmd_ready;
         @(posedge clk); #1;
         bus.cmd_done = 1'b0; bus.cmd_nack = 1'b0;
         if (s_acc) begin
            s_busy = 1'b1;
            s_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
            s_cnt  = det_mode ? det_done_dly : int'($urandom_range(0, 4));
         end else if (s_busy) begin
            if (s_cnt == 0) begin
               bus.cmd_done = 1'b1; bus.cmd_nack = s_nack; s_busy = 1'b0;
            end else begin
               s_cnt--;
            end
         end
         if (hold_ready || s_busy) bus.cmd_ready = 1'b0;
         else if (det_mode)        bus.cmd_ready = 1'b1;
         else                      bus.cmd_ready = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_end(input string name);
      int n = 0;
      while (!(done || error) && n < 3000) begin
         @(posedge clk); #1; n++;
      end
      if (!(done || error)) begin
         tests++; fails++;
         $display("FAIL %s_timeout actual=busy required=done_or_error", name);
      end
   endtask

   task automatic finish_check(input string name, input bit e_done, input bit e_err, input int e_idx);
      repeat (20) @(posedge clk);
      #1;
      $display("[TB] run %s: done=%0d error=%0d err_index=%0d", name, done, error, err_index);
      check({name, "_done"}, 32'(done), 32'(e_done));
      check({name, "_error"}, 32'(error), 32'(e_err));
      check({name, "_busy"}, 32'(busy), 32'(0));
      check({name, "_pwdn"}, 32'(pwdn_n), 32'(e_done));
      check({name, "_resetn"}, 32'(reset_n), 32'(e_done));
      if (e_err) check({name, "_err_index"}, 32'(err_index), 32'(e_idx));
      check({name, "_pending"}, 32'(exp_q.size()), 32'(0));
      check({name, "_cmd_valid"}, 32'(bus.cmd_valid), 32'(0));
   endtask

   int nacks [P_NR];
   bit e_done, e_err;
   int e_idx, n, gap3, gap0;

   initial begin
      rst_n = 1'b1; start = 1'b0; pll_locked = 1'b0;
      tbl = '{24'h3000_12, 24'hFFFF_03, 24'h3001_34};
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pwdn", 32'(pwdn_n), 0);
      check("rst_resetn", 32'(reset_n), 0);
      check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
      check("rst_rom_addr", 32'(rom_addr), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_error", 32'(error), 0);
      check("rst_err_index", 32'(err_index), 0);
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Power sequencing timing plus delay entry of 3 units.
      det_mode = 1'b1;
      nacks = '{0, 0, 0};
      plan(nacks, e_done, e_err, e_idx);
      acc_cyc.delete();
      pulse_start();
      repeat (3) @(negedge clk);
      check("busy_after_start", 32'(busy), 1);
      check("pwdn_wait_lock", 32'(pwdn_n), 0);
      pll_locked = 1'b1;
      // The first edge registers lock; PWDN_DLY hold edges follow.
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!pwdn_n && n < 100);
      check("pwdn_rise_edges", 32'(n), 32'(P_PWDN + 1));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!reset_n && n < 100);
      check("resetn_rise_edges", 32'(n), 32'(P_RST));
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!bus.cmd_valid && n < 200);
      check("boot_wait_min", 32'(n >= P_BOOT && n < 200), 1);
      wait_end("timing");
      finish_check("timing", e_done, e_err, e_idx);
      gap3 = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1000;

      // Same table with a zero-length delay: write gap must shrink by 3*DLY_UNIT.
      tbl[1] = 24'hFFFF_00;
      plan(nacks, e_done, e_err, e_idx);
      acc_cyc.delete();
      pulse_start();
      wait_end("zero_delay");
      finish_check("zero_delay", e_done, e_err, e_idx);
      gap0 = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : 1000;
      check("delay_gap_cycles", 32'(gap3 - gap0), 32'(3 * P_DU));

      // Entry 1 NACKed once then ACKed.
      det_mode = 1'b0;
      tbl = '{24'h3000_12, 24'h3002_56, 24'h3001_34};
      nacks = '{0, 1, 0};
      plan(nacks, e_done, e_err, e_idx);
      pulse_start();
      wait_end("retry_once");
      finish_check("retry_once", e_done, e_err, e_idx);

      // Entry 2 NACKed twice: retries exhausted.
      nacks = '{0, 0, 2};
      plan(nacks, e_done, e_err, e_idx);
      pulse_start();
      wait_end("retry_fail");
      finish_check("retry_fail", e_done, e_err, e_idx);

      // Lock lost while a request waits for ready.
      hold_ready = 1'b1;
      exp_q.delete(); nack_q.delete();
      pulse_start();
      n = 0;
      while (!bus.cmd_valid && n < 300) begin @(posedge clk); #1; n++; end
      check("lockloss_reached_issue", 32'(bus.cmd_valid), 1);
      @(negedge clk); pll_locked = 1'b0;
      @(posedge clk); #1;
      check("lockloss_cmd_valid", 32'(bus.cmd_valid), 0);
      check("lockloss_pwdn", 32'(pwdn_n), 0);
      check("lockloss_resetn", 32'(reset_n), 0);
      check("lockloss_error", 32'(error), 1);
      check("lockloss_busy", 32'(busy), 0);
      check("lockloss_err_index", 32'(err_index), 0);
      hold_ready = 1'b0;
      @(negedge clk); pll_locked = 1'b1;

      // Randomized tables, NACK patterns and handshake latencies.
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < P_NR; i++) begin
            if ($urandom_range(0, 3) == 0)
               tbl[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
            else
               tbl[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom_range(0, 255))};
            nacks[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
         end
         plan(nacks, e_done, e_err, e_idx);
         pulse_start();
         wait_end("random");
         finish_check("random", e_done, e_err, e_idx);
      end

      // Asynchronous reset while a transfer is in flight.
      det_mode = 1'b1; det_done_dly = 20;
      tbl = '{24'h3000_12, 24'h3002_56, 24'h3001_34};
      nacks = '{0, 0, 0};
      plan(nacks, e_done, e_err, e_idx);
      acc_cyc.delete();
      pulse_start();
      n = 0;
      while (acc_cyc.size() == 0 && n < 300) begin @(posedge clk); #1; n++; end
      @(posedge clk); #2;
      check("busy_before_reset", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("areset_pwdn", 32'(pwdn_n), 0);
      check("areset_resetn", 32'(reset_n), 0);
      check("areset_cmd_valid", 32'(bus.cmd_valid), 0);
      check("areset_busy", 32'(busy), 0);
      check("areset_done", 32'(done), 0);
      check("areset_error", 32'(error), 0);
      check("areset_rom_addr", 32'(rom_addr), 0);
      check("areset_err_index", 32'(err_index), 0);
      exp_q.delete(); nack_q.delete(); s_busy = 1'b0;
      repeat (2) @(posedge clk);

      // Start on the first edge after reset release is ignored.
      @(negedge clk); rst_n = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("start_at_reset_release", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
